sl_receiver: RTL and testbench

SL_RECEIVER -- requirements
Module: sl_receiver

---
 rtl/sl_pkg.sv | 32 +++
 rtl/sl_line_sync.sv | 59 +++++
 rtl/sl_receiver.sv | 195 +++++++++++++++++++
 tb/tb_sl_receiver.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/sl_pkg.sv
// Shared types and constants for the SL receiver: FSM states, register map,
// status bit positions and the reset word length.
package sl_pkg;

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        BIT,
        GAP,
        STOP
    } sl_state_e;

    localparam logic ADDR_DATA = 1'b0;
    localparam logic ADDR_CFG  = 1'b1;

    localparam int ST_EN    = 6;
    localparam int ST_BUSY  = 16;
    localparam int ST_READY = 17;
    localparam int ST_PAR   = 18;
    localparam int ST_LEN   = 19;
    localparam int ST_OVR   = 20;
    localparam int ST_TMO   = 21;
    localparam int ST_CNT   = 24;

    localparam logic [5:0] CFG_LEN_DEF = 6'd8;

    // Word lengths outside 1..32 are not representable in the data register.
    function automatic logic [5:0] clamp_len(input logic [5:0] len);
        return (len == 6'd0 || len > 6'd32) ? 6'd32 : len;
    endfunction

endpackage

// File: rtl/sl_line_sync.sv
// One SL line: 2-flop synchronizer, then an optional stability filter that
// is built only when SL_RX_GLITCH_FILTER_EN is defined.
module sl_line_sync #(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic line_in,
    output logic line_out
);

    if (FILT_LEN < 1 || FILT_LEN > 15) begin : g_bad_filt_len
        $error("sl_line_sync: FILT_LEN out of range 1..15");
    end

    logic s1_q, s2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= line_in;
            s2_q <= s1_q;
        end
    end

`ifdef SL_RX_GLITCH_FILTER_EN
    localparam logic [3:0] FL = 4'(FILT_LEN);

    logic       filt_q, filt_d;
    logic [3:0] cnt_q, cnt_d;

    // A new level is accepted only after FILT_LEN consecutive cycles of disagreement.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (s2_q != filt_q) begin
            if (cnt_q + 4'd1 >= FL) filt_d = s2_q;
            else                    cnt_d  = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_q <= 1'b1;
            cnt_q  <= '0;
        end else begin
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign line_out = filt_q;
`else
    assign line_out = s2_q;
`endif

endmodule

// File: rtl/sl_receiver.sv
// SL two-wire serial receiver with a two-register CPU interface.
// Glitch filtering on the lines is built when SL_RX_GLITCH_FILTER_EN is defined.
module sl_receiver
    import sl_pkg::*;
#(
    parameter int FILT_LEN = 3,
    parameter int TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SL0,
    input  logic        SL1,
    input  logic [31:0] d_in,
    input  logic        wr_en,
    input  logic        addr,
    output logic [31:0] d_out
);

    if (TIMEOUT < 16 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("sl_receiver: TIMEOUT out of range 16..65535");
    end

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    logic l0, l1;

    sl_line_sync #(.FILT_LEN(FILT_LEN)) u_sync0 (.clk(clk), .rst(rst), .line_in(SL0), .line_out(l0));
    sl_line_sync #(.FILT_LEN(FILT_LEN)) u_sync1 (.clk(clk), .rst(rst), .line_in(SL1), .line_out(l1));

    sl_state_e   state_q, state_d;
    logic [32:0] shift_q, shift_d;
    logic [5:0]  cnt_q, cnt_d, last_q, last_d, cfg_len_q, cfg_len_d;
    logic [15:0] tmr_q, tmr_d;
    logic [1:0]  lines_q;
    logic [31:0] data_q, data_d;
    logic        en_q, en_d, ready_q, ready_d, par_q, par_d;
    logic        len_q, len_d, ovr_q, ovr_d, tmo_q, tmo_d;

    logic        one_lo, both_hi, both_lo, changed, evaluate, zero_stop, tmo_hit;
    logic [32:0] mask, word;

    assign one_lo  = l0 ^ l1;
    assign both_hi = l0 & l1;
    assign both_lo = ~(l0 | l1);
    assign changed = {l0, l1} != lines_q;
    // Keep only the cfg_len data bits plus parity; a shift by 33 yields an all-ones mask.
    assign mask    = (33'd1 << (cfg_len_q + 6'd1)) - 33'd1;
    assign word    = shift_q & mask;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        tmr_d     = '0;
        evaluate  = 1'b0;
        zero_stop = 1'b0;
        tmo_hit   = 1'b0;
        case (state_q)
            WAIT_IDLE: if (both_hi) state_d = IDLE;
            IDLE: begin
                if (one_lo) begin
                    state_d = BIT;
                    shift_d = {shift_q[31:0], l0};
                    cnt_d   = 6'd1;
                end else if (both_lo) begin
                    state_d   = STOP;
                    zero_stop = 1'b1;
                end
            end
            BIT, GAP: begin
                if (both_lo) begin
                    state_d  = STOP;
                    evaluate = 1'b1;
                end else if (state_q == GAP && one_lo) begin
                    state_d = BIT;
                    shift_d = {shift_q[31:0], l0};
                    cnt_d   = (cnt_q == 6'd63) ? cnt_q : cnt_q + 6'd1;
                end else if (state_q == BIT && both_hi) begin
                    state_d = GAP;
                end else if (!changed) begin
                    if (tmr_q == TMO_LAST) begin
                        state_d = WAIT_IDLE;
                        tmo_hit = 1'b1;
                    end else begin
                        tmr_d = tmr_q + 16'd1;
                    end
                end
            end
            STOP:    if (both_hi) state_d = IDLE;
            default: state_d = WAIT_IDLE;
        endcase
        if (!en_q) begin
            state_d   = WAIT_IDLE;
            shift_d   = shift_q;
            cnt_d     = cnt_q;
            tmr_d     = tmr_q;
            evaluate  = 1'b0;
            zero_stop = 1'b0;
            tmo_hit   = 1'b0;
        end
    end

    // Register writes first; receive events applied afterwards take precedence.
    always_comb begin
        data_d    = data_q;
        cfg_len_d = cfg_len_q;
        en_d      = en_q;
        ready_d   = ready_q;
        par_d     = par_q;
        len_d     = len_q;
        ovr_d     = ovr_q;
        tmo_d     = tmo_q;
        last_d    = last_q;
        if (wr_en) begin
            if (addr == ADDR_DATA) begin
                ready_d = 1'b0;
            end else begin
                cfg_len_d = clamp_len(d_in[5:0]);
                en_d      = d_in[6];
                par_d     = 1'b0;
                len_d     = 1'b0;
                ovr_d     = 1'b0;
                tmo_d     = 1'b0;
            end
        end
        if (evaluate) begin
            last_d  = cnt_q;
            ready_d = 1'b1;
            if (ready_q && !(wr_en && addr == ADDR_DATA)) ovr_d = 1'b1;
            if (cnt_q == cfg_len_q + 6'd1) begin
                data_d = word[32:1];
                par_d  = ~(^word);
            end else begin
                len_d = 1'b1;
            end
        end
        if (zero_stop) begin
            len_d  = 1'b1;
            last_d = '0;
        end
        if (tmo_hit) tmo_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= WAIT_IDLE;
            shift_q   <= '0;
            cnt_q     <= '0;
            tmr_q     <= '0;
            lines_q   <= 2'b11;
            data_q    <= '0;
            cfg_len_q <= CFG_LEN_DEF;
            en_q      <= 1'b1;
            ready_q   <= 1'b0;
            par_q     <= 1'b0;
            len_q     <= 1'b0;
            ovr_q     <= 1'b0;
            tmo_q     <= 1'b0;
            last_q    <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            tmr_q     <= tmr_d;
            lines_q   <= {l0, l1};
            data_q    <= data_d;
            cfg_len_q <= cfg_len_d;
            en_q      <= en_d;
            ready_q   <= ready_d;
            par_q     <= par_d;
            len_q     <= len_d;
            ovr_q     <= ovr_d;
            tmo_q     <= tmo_d;
            last_q    <= last_d;
        end
    end

    always_comb begin
        d_out = '0;
        if (addr == ADDR_DATA) begin
            d_out = data_q;
        end else begin
            d_out[5:0]         = cfg_len_q;
            d_out[ST_EN]       = en_q;
            d_out[ST_BUSY]     = (state_q == BIT) || (state_q == GAP) || (state_q == STOP);
            d_out[ST_READY]    = ready_q;
            d_out[ST_PAR]      = par_q;
            d_out[ST_LEN]      = len_q;
            d_out[ST_OVR]      = ovr_q;
            d_out[ST_TMO]      = tmo_q;
            d_out[ST_CNT +: 6] = last_q;
        end
    end

endmodule

// File: tb/tb_sl_receiver.sv
// Directed bench for sl_receiver: words driven on SL0/SL1, registers read back
// and compared against hand-computed values.
module tb_sl_receiver;

    localparam int HOLD = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        SL0, SL1;
    logic [31:0] d_in;
    logic        wr_en;
    logic        addr;
    logic [31:0] d_out;

    int total = 0;
    int bad   = 0;

    sl_receiver #(.FILT_LEN(3), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst), .SL0(SL0), .SL1(SL1),
        .d_in(d_in), .wr_en(wr_en), .addr(addr), .d_out(d_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic rd(input logic a, output logic [31:0] v);
        @(negedge clk);
        addr = a;
        #1 v = d_out;
    endtask

    task automatic wr(input logic a, input logic [31:0] d);
        @(negedge clk);
        addr  = a;
        d_in  = d;
        wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic sym(input logic s0, input logic s1);
        @(negedge clk);
        SL0 = s0;
        SL1 = s1;
        repeat (HOLD) @(negedge clk);
        SL0 = 1'b1;
        SL1 = 1'b1;
        repeat (HOLD) @(negedge clk);
    endtask

    // Bits are sent MSB first: bit 1 drops SL1, bit 0 drops SL0.
    task automatic send_bits(input logic [32:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            if (v[i]) sym(1'b1, 1'b0);
            else      sym(1'b0, 1'b1);
        end
    endtask

    task automatic send_word(input logic [31:0] v, input int n, input logic flip);
        logic p;
        p = ~(^v) ^ flip;
        send_bits({v, p}, n + 1);
        sym(1'b0, 1'b0);
    endtask

    logic [31:0] v;

    initial begin
        rst = 1'b1; SL0 = 1'b1; SL1 = 1'b1; d_in = '0; wr_en = 1'b0; addr = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        rd(1'b0, v); chk("reset_data", v, 32'h0000_0000);
        rd(1'b1, v); chk("reset_status", v, 32'h0000_0048);
        repeat (HOLD) @(negedge clk);

        send_word(32'hA5, 8, 1'b0);
        rd(1'b1, v); chk("a5_status", v, 32'h0902_0048);
        rd(1'b0, v); chk("a5_data", v, 32'h0000_00A5);
        wr(1'b0, 32'h0);
        rd(1'b1, v); chk("rd_clears_ready", v, 32'h0900_0048);

        wr(1'b1, 32'h60);
        rd(1'b1, v); chk("cfg32_status", v, 32'h0900_0060);
        send_word(32'hDEADBEEF, 32, 1'b1);
        rd(1'b0, v); chk("w32_data", v, 32'hDEAD_BEEF);
        rd(1'b1, v); chk("w32_parity_err", v, 32'h2106_0060);

        wr(1'b0, 32'h0);
        wr(1'b1, 32'h50);
        send_bits(33'h2AB, 10);
        sym(1'b0, 1'b0);
        rd(1'b1, v); chk("short_len_err", v, 32'h0A0A_0050);
        rd(1'b0, v); chk("short_data_kept", v, 32'hDEAD_BEEF);

        wr(1'b1, 32'h48);
        wr(1'b0, 32'h0);
        send_word(32'h3C, 8, 1'b0);
        send_word(32'h81, 8, 1'b0);
        rd(1'b1, v); chk("overrun_status", v, 32'h0912_0048);
        rd(1'b0, v); chk("overrun_data", v, 32'h0000_0081);
        wr(1'b1, 32'h48);
        rd(1'b1, v); chk("overrun_cleared", v, 32'h0902_0048);

        wr(1'b0, 32'h0);
        send_bits(33'h2, 2);
        @(negedge clk);
        SL0 = 1'b0;
        repeat (100) @(negedge clk);
        rd(1'b1, v); chk("stuck_busy", v & 32'h0001_0000, 32'h0001_0000);
        repeat (200) @(negedge clk);
        SL0 = 1'b1;
        repeat (HOLD) @(negedge clk);
        rd(1'b1, v); chk("timeout_status", v, 32'h0920_0048);
        send_word(32'h5A, 8, 1'b0);
        rd(1'b0, v); chk("post_tmo_data", v, 32'h0000_005A);
        rd(1'b1, v); chk("post_tmo_status", v, 32'h0922_0048);

        wr(1'b1, 32'h48);
        wr(1'b0, 32'h0);
        sym(1'b0, 1'b0);
        rd(1'b1, v); chk("zero_bit_stop", v & 32'h000A_0000, 32'h0008_0000);

        wr(1'b1, 32'h08);
        send_word(32'h11, 8, 1'b0);
        rd(1'b0, v); chk("disabled_data", v, 32'h0000_005A);
        rd(1'b1, v); chk("disabled_idle", v & 32'h0003_0040, 32'h0000_0000);

        wr(1'b1, 32'h40);
        rd(1'b1, v); chk("cfg0_clamp", v & 32'h7F, 32'h60);
        wr(1'b1, 32'h7F);
        rd(1'b1, v); chk("cfg63_clamp", v & 32'h7F, 32'h60);
        wr(1'b1, 32'h48);
        repeat (HOLD) @(negedge clk);

`ifdef SL_RX_GLITCH_FILTER_EN
        wr(1'b0, 32'h0);
        for (int g = 0; g < 5; g++) begin
            @(negedge clk);
            SL1 = 1'b0;
            repeat (2) @(negedge clk);
            SL1 = 1'b1;
            repeat (3) @(negedge clk);
            rd(1'b1, v); chk("glitch_busy", v & 32'h0001_0000, 32'h0);
            repeat (4) @(negedge clk);
        end
        send_word(32'hC3, 8, 1'b0);
        rd(1'b1, v); chk("glitch_then_word", v, 32'h0902_0048);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
